// File: rtl/ram_scan_ctrl.sv
// ram_scan_ctrl: key-driven exerciser for an on-chip single-port RAM (read, write, pattern fill, auto-scan)
//   CLK    board clock, all logic on posedge
//   RST_N  asynchronous active-low reset; RAM contents survive it
//   KEY_N  raw active-low push-button, asynchronous to CLK
//   MODE   command select: 00 read, 01 write, 10 fill, 11 scan
//   ADDR   command address, or start address for scan
//   DIN    write data, or fill base value
//   DOUT   last read or written word
//   AOUT   address belonging to DOUT (current address while filling)
//   BUSY   a command is executing
//   DONE   one-cycle pulse when a command completes
//   WREN   a RAM write is committed in this cycle
module ram_scan_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int DEBOUNCE = 16,
    parameter int DWELL    = 50_000_000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              KEY_N,
    input  logic [1:0]        MODE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DIN,
    output logic [DATA_W-1:0] DOUT,
    output logic [ADDR_W-1:0] AOUT,
    output logic              BUSY,
    output logic              DONE,
    output logic              WREN
);
    localparam int DBW = $clog2(DEBOUNCE + 1);
    localparam int DWW = $clog2(DWELL);
    localparam int CW  = ADDR_W > DWW ? ADDR_W : DWW;

    typedef enum logic [2:0] {IDLE, READ, WRITE, FILL, SCAN_RD, SCAN_HOLD} state_t;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    state_t            state, nstate;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] addr_l, wa;
    logic [DATA_W-1:0] din_l, wd;
    logic              fill_last, hold_last;
    logic              k_meta, k_sync, pressed, armed, go;
    logic [DBW-1:0]    db_cnt;

    // Synchroniser resets to the pressed level so a key held through reset
    // never looks released; GO is only armed once a real release is seen.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            k_meta  <= 1'b1;
            k_sync  <= 1'b1;
            pressed <= 1'b0;
            armed   <= 1'b0;
            db_cnt  <= '0;
            go      <= 1'b0;
        end else begin
            k_meta  <= ~KEY_N;
            k_sync  <= k_meta;
            go      <= 1'b0;
            armed   <= armed | (~k_sync & ~pressed);
            if (k_sync == pressed) db_cnt <= '0;
            else if (db_cnt == DBW'(DEBOUNCE - 1)) begin
                db_cnt  <= '0;
                pressed <= k_sync;
                go      <= k_sync & armed;
            end else db_cnt <= db_cnt + 1'b1;
        end
    end

    assign fill_last = cnt[ADDR_W-1:0] == '1;
    // Hold covers DWELL-1 cycles; the following SCAN_RD cycle completes the dwell.
    assign hold_last = cnt == CW'(DWELL - 2);
    assign wa        = state == FILL ? cnt[ADDR_W-1:0] : addr_l;
    assign wd        = state == FILL ? din_l + DATA_W'(cnt[ADDR_W-1:0]) : din_l;
    assign BUSY      = state != IDLE;
    assign WREN      = state == WRITE || state == FILL;

    always_comb begin
        nstate = state;
        case (state)
            IDLE:      if (go) nstate = MODE == 2'b00 ? READ : MODE == 2'b01 ? WRITE : MODE == 2'b10 ? FILL : SCAN_RD;
            READ,
            WRITE:     nstate = IDLE;
            FILL:      nstate = fill_last ? IDLE : FILL;
            SCAN_RD:   nstate = go ? IDLE : SCAN_HOLD;
            SCAN_HOLD: nstate = go ? IDLE : hold_last ? SCAN_RD : SCAN_HOLD;
            default:   nstate = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (WREN) mem[wa] <= wd;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_l <= '0;
            din_l  <= '0;
            DOUT   <= '0;
            AOUT   <= '0;
            DONE   <= 1'b0;
        end else begin
            state <= nstate;
            DONE  <= BUSY && nstate == IDLE;
            cnt   <= (state == FILL || (state == SCAN_HOLD && !hold_last)) ? cnt + 1'b1 : '0;
            if (state == IDLE && go) begin
                addr_l <= ADDR;
                din_l  <= DIN;
            end
            if (state == SCAN_HOLD && hold_last && !go) addr_l <= addr_l + 1'b1;
            // A stop GO in SCAN_RD discards the read so outputs keep the last shown word.
            if (WREN) begin
                DOUT <= wd;
                AOUT <= wa;
            end else if (state == READ || (state == SCAN_RD && !go)) begin
                DOUT <= mem[addr_l];
                AOUT <= addr_l;
            end
        end
    end
endmodule

// File: tb/tb_ram_scan_ctrl.sv
// tb_ram_scan_ctrl: scoreboard bench for ram_scan_ctrl with short debounce and dwell
module tb_ram_scan_ctrl;
    localparam int DW = 8, AW = 5, DB = 4, DWL = 8;

    typedef struct packed {logic [DW-1:0] d; logic [AW-1:0] a;} exp_t;

    logic          CLK = 1'b0, RST_N = 1'b0, KEY_N = 1'b1;
    logic [1:0]    MODE = 2'b00;
    logic [AW-1:0] ADDR = '0;
    logic [DW-1:0] DIN = '0;
    logic [DW-1:0] DOUT;
    logic [AW-1:0] AOUT;
    logic          BUSY, DONE, WREN;
    int            tests = 0, fails = 0;
    exp_t          exp_q[$];

    ram_scan_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEBOUNCE(DB), .DWELL(DWL)) dut (
        .CLK(CLK), .RST_N(RST_N), .KEY_N(KEY_N), .MODE(MODE), .ADDR(ADDR), .DIN(DIN),
        .DOUT(DOUT), .AOUT(AOUT), .BUSY(BUSY), .DONE(DONE), .WREN(WREN)
    );

    always #5 CLK = ~CLK;

    // Press at the current negedge (sample cycle k = j 0), release at j 12, observe 24 cycles.
    task automatic run_cmd(input logic [1:0] m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int busy_at, output int wren_at, output int done_at,
                           output int wren_n, output int done_n,
                           output logic [DW-1:0] dq, output logic [AW-1:0] aq);
        MODE = m; ADDR = a; DIN = d;
        busy_at = -1; wren_at = -1; done_at = -1; wren_n = 0; done_n = 0; dq = '0; aq = '0;
        KEY_N = 1'b0;
        for (int j = 1; j <= 24; j++) begin
            @(negedge CLK);
            if (BUSY && busy_at < 0) busy_at = j;
            if (WREN) begin wren_n++; if (wren_at < 0) wren_at = j; end
            if (DONE) begin
                done_n++;
                if (done_at < 0) begin done_at = j; dq = DOUT; aq = AOUT; end
            end
            if (j == 12) KEY_N = 1'b1;
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        tests++; if ({DOUT, AOUT, BUSY, DONE, WREN} !== 16'h0) begin fails++; $display("FAIL reset_vals: got %h expected 0000", {DOUT, AOUT, BUSY, DONE, WREN}); end
        RST_N = 1'b1;
        repeat (6) @(negedge CLK);
        tests++; if ({BUSY, DONE} !== 2'b00) begin fails++; $display("FAIL reset_idle: got %b expected 00", {BUSY, DONE}); end
    endtask

    task automatic test_write_read();
        int ba, wa, da, wn, dn; logic [DW-1:0] dq; logic [AW-1:0] aq; exp_t e;
        exp_q.push_back({8'hA5, 5'h13});
        run_cmd(2'b01, 5'h13, 8'hA5, ba, wa, da, wn, dn, dq, aq);
        e = exp_q.pop_front();
        tests++; if (ba !== 7) begin fails++; $display("FAIL wr_busy_cycle: got %0d expected 7", ba); end
        tests++; if (wa !== 7 || wn !== 1) begin fails++; $display("FAIL wr_wren: got at %0d n %0d expected at 7 n 1", wa, wn); end
        tests++; if (da !== 8 || dn !== 1) begin fails++; $display("FAIL wr_done: got at %0d n %0d expected at 8 n 1", da, dn); end
        tests++; if ({dq, aq} !== e) begin fails++; $display("FAIL wr_out: got %h/%h expected %h/%h", dq, aq, e.d, e.a); end
        exp_q.push_back({8'hA5, 5'h13});
        run_cmd(2'b00, 5'h13, 8'h00, ba, wa, da, wn, dn, dq, aq);
        e = exp_q.pop_front();
        tests++; if (ba !== 7) begin fails++; $display("FAIL rd_busy_cycle: got %0d expected 7", ba); end
        tests++; if (da !== 8 || dn !== 1 || wn !== 0) begin fails++; $display("FAIL rd_done: got at %0d n %0d wren %0d expected at 8 n 1 wren 0", da, dn, wn); end
        tests++; if ({dq, aq} !== e) begin fails++; $display("FAIL rd_out: got %h/%h expected %h/%h", dq, aq, e.d, e.a); end
    endtask

    task automatic test_bounce();
        int ba, wa, da, wn, dn, act = 0; logic [DW-1:0] dq; logic [AW-1:0] aq; exp_t e;
        MODE = 2'b00; ADDR = 5'h13;
        for (int i = 0; i < 10; i++) begin
            KEY_N = i[0];
            repeat (2) begin @(negedge CLK); if (BUSY || DONE) act++; end
        end
        tests++; if (act !== 0) begin fails++; $display("FAIL bounce_quiet: got %0d active cycles expected 0", act); end
        exp_q.push_back({8'hA5, 5'h13});
        run_cmd(2'b00, 5'h13, 8'h00, ba, wa, da, wn, dn, dq, aq);
        e = exp_q.pop_front();
        tests++; if (ba !== 7) begin fails++; $display("FAIL bounce_go_cycle: got busy at %0d expected 7", ba); end
        tests++; if (da !== 8 || dn !== 1) begin fails++; $display("FAIL bounce_done: got at %0d n %0d expected at 8 n 1", da, dn); end
        tests++; if ({dq, aq} !== e) begin fails++; $display("FAIL bounce_out: got %h/%h expected %h/%h", dq, aq, e.d, e.a); end
    endtask

    task automatic test_fill();
        int ba = -1, wa = -1, da = -1, wn = 0, dn = 0; logic [DW-1:0] dq = '0; logic [AW-1:0] aq = '0; exp_t e;
        logic [AW-1:0] rb [5] = '{5'h00, 5'h0F, 5'h10, 5'h1F, 5'h13};
        logic [DW-1:0] rv [5] = '{8'hF0, 8'hFF, 8'h00, 8'h0F, 8'h03};
        MODE = 2'b10; ADDR = '0; DIN = 8'hF0;
        exp_q.push_back({8'h0F, 5'h1F});
        KEY_N = 1'b0;
        for (int j = 1; j <= 60; j++) begin
            @(negedge CLK);
            if (BUSY && ba < 0) ba = j;
            if (WREN) begin wn++; if (wa < 0) wa = j; end
            if (DONE) begin dn++; if (da < 0) begin da = j; dq = DOUT; aq = AOUT; end end
            if (j == 12 || j == 34) KEY_N = 1'b1;
            if (j == 22) KEY_N = 1'b0;
        end
        e = exp_q.pop_front();
        tests++; if (ba !== 7 || wa !== 7) begin fails++; $display("FAIL fill_start: got busy %0d wren %0d expected 7 7", ba, wa); end
        tests++; if (wn !== 32) begin fails++; $display("FAIL fill_wren_count: got %0d expected 32", wn); end
        tests++; if (da !== 39 || dn !== 1) begin fails++; $display("FAIL fill_done: got at %0d n %0d expected at 39 n 1", da, dn); end
        tests++; if ({dq, aq} !== e) begin fails++; $display("FAIL fill_out: got %h/%h expected %h/%h", dq, aq, e.d, e.a); end
        for (int i = 0; i < 5; i++) begin
            int b2, w2, d2, wn2, dn2; logic [DW-1:0] q; logic [AW-1:0] qa;
            exp_q.push_back({rv[i], rb[i]});
            run_cmd(2'b00, rb[i], 8'h00, b2, w2, d2, wn2, dn2, q, qa);
            e = exp_q.pop_front();
            tests++; if (d2 !== 8 || {q, qa} !== e) begin fails++; $display("FAIL fill_readback: got %h/%h at %0d expected %h/%h at 8", q, qa, d2, e.d, e.a); end
        end
    endtask

    task automatic test_scan_wrap_stop();
        int dn = 0, wn = 0; exp_t cur = '0, e;
        logic [AW-1:0] sa [5] = '{5'h1E, 5'h1F, 5'h00, 5'h01, 5'h02};
        logic [DW-1:0] sv [5] = '{8'h0E, 8'h0F, 8'hF0, 8'hF1, 8'hF2};
        MODE = 2'b11; ADDR = 5'h1E; DIN = '0;
        for (int i = 0; i < 5; i++) exp_q.push_back({sv[i], sa[i]});
        KEY_N = 1'b0;
        for (int j = 1; j <= 60; j++) begin
            @(negedge CLK);
            if (DONE) dn++;
            if (WREN) wn++;
            if (j % 8 == 7 && j > 8 && j < 40) begin
                tests++; if ({DOUT, AOUT} !== cur) begin fails++; $display("FAIL scan_hold j%0d: got %h/%h expected %h/%h", j, DOUT, AOUT, cur.d, cur.a); end
            end
            if (j % 8 == 0 && j <= 40) begin
                cur = exp_q.pop_front();
                tests++; if ({DOUT, AOUT, BUSY} !== {cur, 1'b1}) begin fails++; $display("FAIL scan_step j%0d: got %h/%h busy %b expected %h/%h busy 1", j, DOUT, AOUT, BUSY, cur.d, cur.a); end
            end
            if (j == 42) begin
                tests++; if (BUSY !== 1'b1) begin fails++; $display("FAIL scan_busy_at_go: got %b expected 1", BUSY); end
            end
            if (j == 43) begin
                tests++; if ({BUSY, DONE, DOUT, AOUT} !== {2'b01, cur}) begin fails++; $display("FAIL scan_stop: got busy %b done %b %h/%h expected 0 1 %h/%h", BUSY, DONE, DOUT, AOUT, cur.d, cur.a); end
            end
            if (j == 50) begin
                tests++; if ({BUSY, DOUT, AOUT} !== {1'b0, cur}) begin fails++; $display("FAIL scan_after_stop: got busy %b %h/%h expected 0 %h/%h", BUSY, DOUT, AOUT, cur.d, cur.a); end
            end
            if (j == 12 || j == 48) KEY_N = 1'b1;
            if (j == 36) KEY_N = 1'b0;
        end
        tests++; if (dn !== 1 || wn !== 0) begin fails++; $display("FAIL scan_pulses: got done %0d wren %0d expected 1 0", dn, wn); end
    endtask

    task automatic test_reset_mid();
        int act = 0; exp_t e;
        logic [AW-1:0] rb [4] = '{5'h04, 5'h05, 5'h13, 5'h1F};
        logic [DW-1:0] rv [4] = '{8'h04, 8'hF5, 8'h03, 8'h0F};
        MODE = 2'b11; ADDR = 5'h05; KEY_N = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge CLK);
            if (j == 12) KEY_N = 1'b1;
        end
        tests++; if ({BUSY, DOUT, AOUT} !== {1'b1, 8'hF6, 5'h06}) begin fails++; $display("FAIL rst_scan_pre: got busy %b %h/%h expected 1 f6/06", BUSY, DOUT, AOUT); end
        RST_N = 1'b0; #1;
        tests++; if ({DOUT, AOUT, BUSY, DONE, WREN} !== 16'h0) begin fails++; $display("FAIL rst_scan_zero: got %h expected 0000", {DOUT, AOUT, BUSY, DONE, WREN}); end
        @(negedge CLK); RST_N = 1'b1;
        repeat (6) @(negedge CLK);
        MODE = 2'b10; ADDR = '0; DIN = 8'h00; KEY_N = 1'b0;
        repeat (12) @(negedge CLK);
        tests++; if ({BUSY, WREN, DOUT, AOUT} !== {2'b11, 8'h04, 5'h04}) begin fails++; $display("FAIL rst_fill_pre: got %b%b %h/%h expected 11 04/04", BUSY, WREN, DOUT, AOUT); end
        RST_N = 1'b0; #1;
        tests++; if ({DOUT, AOUT, BUSY, DONE, WREN} !== 16'h0) begin fails++; $display("FAIL rst_fill_zero: got %h expected 0000", {DOUT, AOUT, BUSY, DONE, WREN}); end
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        for (int j = 0; j < 20; j++) begin @(negedge CLK); if (BUSY || DONE) act++; end
        tests++; if (act !== 0) begin fails++; $display("FAIL rst_held_key: got %0d active cycles expected 0", act); end
        KEY_N = 1'b1;
        repeat (10) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            int b2, w2, d2, wn2, dn2; logic [DW-1:0] q; logic [AW-1:0] qa;
            exp_q.push_back({rv[i], rb[i]});
            run_cmd(2'b00, rb[i], 8'h00, b2, w2, d2, wn2, dn2, q, qa);
            e = exp_q.pop_front();
            tests++; if (d2 !== 8 || {q, qa} !== e) begin fails++; $display("FAIL rst_readback: got %h/%h at %0d expected %h/%h at 8", q, qa, d2, e.d, e.a); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bounce();
        test_fill();
        test_scan_wrap_stop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
